multi_alarm_clock: RTL and testbench
====================================

# multi_alarm_clock

Parametrised 24-hour clock with NUM_ALARMS independently programmable alarm slots, per-slot arming and optional snooze. Runs entirely in the `clock` domain and derives seconds from a clock-enable tick, with no generated clock. Time is kept directly in BCD digits. The block sits between the board switch/button front end and the display and buzzer drivers; `Alarm` feeds the tone generator unchanged.

## Interface
- CLK_FREQ_HZ, 100_000_000, input clock frequency; one second = CLK_FREQ_HZ cycles
- NUM_ALARMS, 4, number of alarm slots (1..16)
- SNOOZE_MIN, 5, snooze length in minutes (1..59)
- Clocking and reset (already decided): one clock, `clock`; `reset` is synchronous, active-high.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hour_in1  in  2  hour tens digit for load (0..2)
- hour_in0  in  4  hour units digit for load (0..9)
- minute_in1  in  4  minute tens digit for load (0..5)
- minute_in0  in  4  minute units digit for load (0..9)
- load_time  in  1  write hh:mm to the clock, seconds := 00
- load_alarm  in  1  write hh:mm to slot alarm_sel
- alarm_sel  in  $clog2(NUM_ALARMS) (min 1)  slot index for load_alarm
- alarm_arm  in  NUM_ALARMS  per-slot arm mask, sampled every cycle
- STOP_alarm  in  1  silence the alarm, return to IDLE
- snooze  in  1  defer the ringing alarm by SNOOZE_MIN
- Alarm  out  1  high while ringing
- alarm_src  out  $clog2(NUM_ALARMS)  slot that caused the current ring/snooze
- load_err  out  1  one-cycle pulse: rejected load
- tick_1s  out  1  one-cycle pulse per second
- hour_out1, hour_out0, minute_out1, minute_out0  out  2/4/4/4  current time, BCD
- seconds  out  6  current seconds, binary 0..59

## Operation
- **Second tick:** prescaler counts 0..CLK_FREQ_HZ-1. `tick_1s` pulses on the terminal count.
- **Time advance:** on tick, seconds increments. At 59 it wraps to 0 and carries into the minute units digit. The carry chain runs minute units 9→0, minute tens 5→0, hours, with 23:59:59 → 00:00:00.
- **load_time:**
  - Takes priority over a tick in the same cycle.
  - Sets hh:mm from the inputs, seconds to 00, and clears the prescaler.
- **Load validation:** a load is rejected if the input is out of range:
  - hour > 23, or
  - minute_in1 > 5, or
  - hour_in0 > 9, or
  - minute_in0 > 9.
  
  A rejected load leaves state unchanged and pulses `load_err`. The same check applies to load_alarm.
- **Simultaneous loads:** if load_time and load_alarm are both high, both are performed (same hh:mm).
- **Alarm slots:** each slot holds hh:mm. Reset value is 24:00, which never matches. A slot matches when it is armed and the current time equals slot:00.
- **Match evaluation:** one cycle after each tick, against the registered time.
- **Multiple matches:** if several slots match, the lowest index wins.
- **FSM states:** IDLE, RINGING, SNOOZED.
- **IDLE:** match → RINGING; alarm_src := slot.
- **RINGING:**
  - Alarm = 1.
  - STOP_alarm → IDLE.
  - snooze → SNOOZED; snooze counter := SNOOZE_MIN*60.
  - New matches are ignored.
- **SNOOZED:**
  - Alarm = 0.
  - The counter decrements per tick; on reaching 0 → RINGING with the same alarm_src.
  - STOP_alarm → IDLE.
  - A new match from any slot → RINGING with the new alarm_src; the counter is discarded.
- **Simultaneous events:**
  - STOP_alarm and snooze together: STOP wins.
  - STOP_alarm and a match evaluated in the same cycle: STOP wins, so the state ends in IDLE.
- **Disarming:** clearing a slot's arm bit while RINGING or SNOOZED from that slot returns the FSM to IDLE on the next cycle.
- **Effect of loads on the FSM:** load_time and load_alarm do not change the FSM state.

## Timing
- **Reset (synchronous):** applied on the next clock edge with reset high.
  - Time 00:00:00, prescaler 0.
  - All slots 24:00.
  - FSM IDLE.
  - Alarm, alarm_src, load_err and tick_1s all 0.
- **Load latency:** time outputs reflect load_time on the edge after it is sampled. load_err is asserted on that same edge.
- **Time update:** outputs update on the edge after the tick_1s cycle.
- **Alarm latency:** Alarm rises one edge after the outputs first show the matching hh:mm:00.
- **Level-sensitive inputs:** STOP_alarm and snooze are levels, sampled every cycle (the upstream front end debounces and pulses them). A held snooze acts only on the RINGING→SNOOZED transition.
- **Snooze expiry:** RINGING resumes exactly SNOOZE_MIN*60 ticks after entering SNOOZED.

## Configuration
- SNOOZE_EN defined: SNOOZED state, snooze counter and snooze input are present.
- SNOOZE_EN undefined: snooze is ignored and the FSM is IDLE/RINGING only. The counter logic and the SNOOZE_MIN parameter have no effect.

## Structure
- Package `alarm_clock_pkg`:
  - typedef `bcd_time_t` (h1[1:0], h0, m1, m0)
  - `alarm_state_e` {IDLE, RINGING, SNOOZED}
  - constant ALARM_DISABLED_TIME = 24:00
  - function `bcd_time_valid`
- Sub-module `second_tick_gen` (parameter CLK_FREQ_HZ; ports clock, reset, clear, tick).
- Top level holds the BCD counters, slot register array, match priority encoder and FSM.

## Test plan
- Run with CLK_FREQ_HZ=10 so one second = 10 cycles.
- **Rollover:** load_time 23:59, run 60 ticks → 00:00:00. Also check 09:59:59 → 10:00:00.
- **Load validation:** load_time 24:10 → load_err one cycle, time unchanged. Repeat with 12:7x → same.
- **Priority:** slots 1 and 3 both at 07:00 and armed, time 06:59:58 → Alarm high at 07:00:00 plus 1 cycle, alarm_src=1. STOP_alarm → Alarm 0 next edge.
- **Snooze:** with SNOOZE_EN and SNOOZE_MIN=1, ringing plus snooze → Alarm 0 for exactly 60 ticks, then 1 with the same alarm_src. STOP and snooze together → IDLE.
- **Disarm:** clear the arm bit of the ringing slot → Alarm 0 next cycle. An unarmed slot at 08:00 never rings.
- **Reset mid-operation:** reset during RINGING and SNOOZED → all outputs 0, time 00:00:00, slots 24:00 (no match at 00:00).

Source files
------------

// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarm_clock_pkg : BCD time type, alarm FSM states and BCD helper functions
// Revision: 1.0
// ---------------------------------------------------------------------------
package alarm_clock_pkg;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_e;

  localparam bcd_time_t TIME_ZERO           = '{h1: 2'd0, h0: 4'd0, m1: 4'd0, m0: 4'd0};
  // 24:00 is never reached by the running clock, so a slot holding it never fires
  localparam bcd_time_t ALARM_DISABLED_TIME = '{h1: 2'd2, h0: 4'd4, m1: 4'd0, m0: 4'd0};

  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic hour_ok;
    hour_ok = (t.h1 < 2'd2) || ((t.h1 == 2'd2) && (t.h0 <= 4'd3));
    return hour_ok && (t.h0 <= 4'd9) && (t.m1 <= 4'd5) && (t.m0 <= 4'd9);
  endfunction

  function automatic bcd_time_t bcd_time_inc_minute(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.m0 != 4'd9) begin
      r.m0 = t.m0 + 4'd1;
    end else begin
      r.m0 = 4'd0;
      if (t.m1 != 4'd5) begin
        r.m1 = t.m1 + 4'd1;
      end else begin
        r.m1 = 4'd0;
        if ((t.h1 == 2'd2) && (t.h0 == 4'd3)) begin
          r.h1 = 2'd0;
          r.h0 = 4'd0;
        end else if (t.h0 == 4'd9) begin
          r.h0 = 4'd0;
          r.h1 = t.h1 + 2'd1;
        end else begin
          r.h0 = t.h0 + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage : alarm_clock_pkg
`default_nettype wire

// File: rtl/second_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// second_tick_gen : prescaler producing a one-cycle tick every CLK_FREQ_HZ cycles
// Revision: 1.0
// ---------------------------------------------------------------------------
module second_tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == C_TERMINAL);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : second_tick_gen
`default_nettype wire

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_alarm_clock : 24h BCD clock with NUM_ALARMS armable alarm slots.
// Optional snooze support is built when SNOOZE_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
module multi_alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int NUM_ALARMS  = 4,
  parameter int SNOOZE_MIN  = 5,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            hour_in1,
  input  logic [3:0]            hour_in0,
  input  logic [3:0]            minute_in1,
  input  logic [3:0]            minute_in0,
  input  logic                  load_time,
  input  logic                  load_alarm,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_arm,
  input  logic                  STOP_alarm,
  input  logic                  snooze,
  output logic                  Alarm,
  output logic [SEL_W-1:0]      alarm_src,
  output logic                  load_err,
  output logic                  tick_1s,
  output logic [1:0]            hour_out1,
  output logic [3:0]            hour_out0,
  output logic [3:0]            minute_out1,
  output logic [3:0]            minute_out0,
  output logic [5:0]            seconds
);

  localparam int SNZ_LOAD = SNOOZE_MIN * 60;
  localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);

  bcd_time_t              w_in_time;
  logic                   w_in_valid;
  logic                   w_load_time_ok;
  logic                   w_tick;
  bcd_time_t              r_time;
  logic [5:0]             r_sec;
  logic                   r_eval;
  logic                   r_load_err;
  bcd_time_t              r_slot [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]  w_hit;
  logic                   w_match;
  logic [SEL_W-1:0]       w_match_idx;
  logic                   w_src_armed;
  alarm_state_e           r_state;
  alarm_state_e           w_state_nxt;
  logic [SEL_W-1:0]       r_src;
  logic [SEL_W-1:0]       w_src_nxt;

  assign w_in_time      = '{h1: hour_in1, h0: hour_in0, m1: minute_in1, m0: minute_in0};
  assign w_in_valid     = bcd_time_valid(w_in_time);
  assign w_load_time_ok = load_time && w_in_valid;

  second_tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_second_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (w_load_time_ok),
    .tick  (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_time     <= TIME_ZERO;
      r_sec      <= 6'd0;
      r_eval     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_eval     <= w_tick;
      r_load_err <= (load_time || load_alarm) && !w_in_valid;
      if (w_load_time_ok) begin
        r_time <= w_in_time;
        r_sec  <= 6'd0;
      end else if (w_tick) begin
        if (r_sec == 6'd59) begin
          r_sec  <= 6'd0;
          r_time <= bcd_time_inc_minute(r_time);
        end else begin
          r_sec  <= r_sec + 6'd1;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
      always_ff @(posedge clock) begin
        if (reset) begin
          r_slot[g] <= ALARM_DISABLED_TIME;
        end else if (load_alarm && w_in_valid && (alarm_sel == SEL_W'(g))) begin
          r_slot[g] <= w_in_time;
        end
      end
      assign w_hit[g] = alarm_arm[g] && (r_slot[g] == r_time);
    end
  endgenerate

  // Scan downwards so the lowest matching index is the one left standing
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_match     = 1'b1;
        w_match_idx = SEL_W'(i);
      end
    end
    w_match = w_match && r_eval && (r_sec == 6'd0);
  end

  assign w_src_armed = alarm_arm[r_src];

`ifdef SNOOZE_EN
  logic [SNZ_W-1:0] r_snz_cnt;
  logic [SNZ_W-1:0] w_snz_cnt_nxt;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = snooze ^ (SNZ_LOAD == 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
`ifdef SNOOZE_EN
    w_snz_cnt_nxt = r_snz_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (!STOP_alarm && w_match) begin
          w_state_nxt = RINGING;
          w_src_nxt   = w_match_idx;
        end
      end
      RINGING: begin
        if (STOP_alarm || !w_src_armed) begin
          w_state_nxt = IDLE;
`ifdef SNOOZE_EN
        end else if (snooze) begin
          w_state_nxt   = SNOOZED;
          w_snz_cnt_nxt = SNZ_W'(SNZ_LOAD);
`endif
        end
      end
`ifdef SNOOZE_EN
      SNOOZED: begin
        if (STOP_alarm || !w_src_armed) begin
          w_state_nxt = IDLE;
        end else if (w_match) begin
          w_state_nxt = RINGING;
          w_src_nxt   = w_match_idx;
        end else if (w_tick) begin
          w_snz_cnt_nxt = r_snz_cnt - SNZ_W'(1);
          if (r_snz_cnt == SNZ_W'(1)) begin
            w_state_nxt = RINGING;
          end
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_src   <= '0;
`ifdef SNOOZE_EN
      r_snz_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
`ifdef SNOOZE_EN
      r_snz_cnt <= w_snz_cnt_nxt;
`endif
    end
  end

  assign Alarm       = (r_state == RINGING);
  assign alarm_src   = r_src;
  assign load_err    = r_load_err;
  assign tick_1s     = w_tick;
  assign hour_out1   = r_time.h1;
  assign hour_out0   = r_time.h0;
  assign minute_out1 = r_time.m1;
  assign minute_out0 = r_time.m0;
  assign seconds     = r_sec;

endmodule : multi_alarm_clock
`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multi_alarm_clock : directed bench with a seconds-of-day reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_multi_alarm_clock;

  localparam int F    = 10;
  localparam int N    = 4;
  localparam int SMIN = 1;
`ifdef SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0, minute_in1, minute_in0;
  logic       load_time, load_alarm;
  logic [1:0] alarm_sel;
  logic [3:0] alarm_arm;
  logic       STOP_alarm, snooze;
  logic       Alarm;
  logic [1:0] alarm_src;
  logic       load_err, tick_1s;
  logic [1:0] hour_out1;
  logic [3:0] hour_out0, minute_out1, minute_out0;
  logic [5:0] seconds;

  always #5 clk = ~clk;

  multi_alarm_clock #(
    .CLK_FREQ_HZ (F),
    .NUM_ALARMS  (N),
    .SNOOZE_MIN  (SMIN)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .hour_in1    (hour_in1),
    .hour_in0    (hour_in0),
    .minute_in1  (minute_in1),
    .minute_in0  (minute_in0),
    .load_time   (load_time),
    .load_alarm  (load_alarm),
    .alarm_sel   (alarm_sel),
    .alarm_arm   (alarm_arm),
    .STOP_alarm  (STOP_alarm),
    .snooze      (snooze),
    .Alarm       (Alarm),
    .alarm_src   (alarm_src),
    .load_err    (load_err),
    .tick_1s     (tick_1s),
    .hour_out1   (hour_out1),
    .hour_out0   (hour_out0),
    .minute_out1 (minute_out1),
    .minute_out0 (minute_out0),
    .seconds     (seconds)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, slots as minutes of day (1440 = off)
  int m_tod, m_pre, m_state, m_src, m_cnt;
  int m_slot [N];
  bit m_err, m_eval, m_ok;

  always @(posedge clk) begin : p_model
    int hh, mm, idx;
    bit tk, vld;
    if (reset) begin
      m_tod = 0; m_pre = 0; m_state = 0; m_src = 0; m_cnt = 0;
      m_err = 0; m_eval = 0; m_ok = 1;
      for (int i = 0; i < N; i++) m_slot[i] = 1440;
    end else if (m_ok) begin
      tk  = (m_pre == F - 1);
      hh  = int'(hour_in1) * 10 + int'(hour_in0);
      mm  = int'(minute_in1) * 10 + int'(minute_in0);
      vld = (hh <= 23) && (hour_in0 <= 9) && (minute_in1 <= 5) && (minute_in0 <= 9);
      idx = -1;
      if (m_eval && (m_tod % 60 == 0))
        for (int i = 0; i < N; i++)
          if (idx < 0 && alarm_arm[i] && m_slot[i] == m_tod / 60) idx = i;
      case (m_state)
        0: if (!STOP_alarm && idx >= 0) begin m_state = 1; m_src = idx; end
        1: begin
          if (STOP_alarm || !alarm_arm[m_src]) m_state = 0;
          else if (SNZ_EN && snooze) begin m_state = 2; m_cnt = SMIN * 60; end
        end
        default: begin
          if (STOP_alarm || !alarm_arm[m_src]) m_state = 0;
          else if (idx >= 0) begin m_state = 1; m_src = idx; end
          else if (tk) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_state = 1;
          end
        end
      endcase
      m_err  = (load_time || load_alarm) && !vld;
      m_eval = tk;
      if (load_time && vld) begin
        m_tod = hh * 3600 + mm * 60;
        m_pre = 0;
      end else begin
        if (tk) m_tod = (m_tod + 1) % 86400;
        m_pre = tk ? 0 : m_pre + 1;
      end
      if (load_alarm && vld) m_slot[alarm_sel] = hh * 60 + mm;
    end
  end

  always @(negedge clk) begin : p_compare
    int h, mi;
    if (m_ok) begin
      h  = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      chk("Alarm",       32'(Alarm),       32'(m_state == 1));
      chk("alarm_src",   32'(alarm_src),   m_src);
      chk("load_err",    32'(load_err),    32'(m_err));
      chk("tick_1s",     32'(tick_1s),     32'(m_pre == F - 1));
      chk("hour_out1",   32'(hour_out1),   h / 10);
      chk("hour_out0",   32'(hour_out0),   h % 10);
      chk("minute_out1", 32'(minute_out1), mi / 10);
      chk("minute_out0", 32'(minute_out0), mi % 10);
      chk("seconds",     32'(seconds),     m_tod % 60);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input int h1, input int h0, input int m1, input int m0);
    hour_in1   = 2'(h1);
    hour_in0   = 4'(h0);
    minute_in1 = 4'(m1);
    minute_in0 = 4'(m0);
  endtask

  task automatic load_t(input int h1, input int h0, input int m1, input int m0);
    set_digits(h1, h0, m1, m0);
    load_time = 1'b1;
    step(1);
    load_time = 1'b0;
  endtask

  task automatic load_a(input int sel, input int h1, input int h0, input int m1, input int m0);
    set_digits(h1, h0, m1, m0);
    alarm_sel  = 2'(sel);
    load_alarm = 1'b1;
    step(1);
    load_alarm = 1'b0;
  endtask

  task automatic chk_time(input string name, input int h1, input int h0,
                          input int m1, input int m0, input int s);
    chk({name, "_h1"}, 32'(hour_out1), h1);
    chk({name, "_h0"}, 32'(hour_out0), h0);
    chk({name, "_m1"}, 32'(minute_out1), m1);
    chk({name, "_m0"}, 32'(minute_out0), m0);
    chk({name, "_s"},  32'(seconds), s);
  endtask

  int bad [4][4] = '{'{2, 4, 1, 0}, '{1, 2, 7, 0}, '{0, 10, 0, 0}, '{1, 0, 3, 10}};

  initial begin
    reset = 1'b1; load_time = 1'b0; load_alarm = 1'b0; alarm_sel = 2'd0;
    alarm_arm = 4'b0000; STOP_alarm = 1'b0; snooze = 1'b0;
    set_digits(0, 0, 0, 0);
    step(3);
    reset = 1'b0;
    chk_time("rst", 0, 0, 0, 0, 0);
    chk("rst_alarm", 32'(Alarm), 0);
    chk("rst_src", 32'(alarm_src), 0);

    // Rollover 23:59 -> 00:00:00 after 60 ticks, then 09:59:59 -> 10:00:00
    load_t(2, 3, 5, 9);
    chk_time("load2359", 2, 3, 5, 9, 0);
    chk("load_ok_err", 32'(load_err), 0);
    step(600);
    chk_time("roll_midnight", 0, 0, 0, 0, 0);
    load_t(0, 9, 5, 9);
    step(590);
    chk_time("pre_10h", 0, 9, 5, 9, 59);
    step(10);
    chk_time("roll_10h", 1, 0, 0, 0, 0);

    // Out-of-range loads are rejected with a one-cycle load_err
    for (int i = 0; i < 4; i++) begin
      set_digits(bad[i][0], bad[i][1], bad[i][2], bad[i][3]);
      load_time = 1'b1;
      step(1);
      load_time = 1'b0;
      chk("bad_load_err", 32'(load_err), 1);
      chk("bad_load_h0", 32'(hour_out0), 0);
      chk("bad_load_h1", 32'(hour_out1), 1);
      step(1);
      chk("bad_load_err_clr", 32'(load_err), 0);
    end
    load_a(0, 2, 5, 0, 0);
    chk("bad_alarm_err", 32'(load_err), 1);

    // Slots 1 and 3 at 07:00: lowest index wins
    load_a(1, 0, 7, 0, 0);
    load_a(3, 0, 7, 0, 0);
    alarm_arm = 4'b1010;
    load_t(0, 6, 5, 9);
    step(580);
    chk_time("t065958", 0, 6, 5, 9, 58);
    step(20);
    chk_time("t0700", 0, 7, 0, 0, 0);
    chk("alarm_before", 32'(Alarm), 0);
    step(1);
    chk("alarm_rise", 32'(Alarm), 1);
    chk("alarm_src_pri", 32'(alarm_src), 1);
    STOP_alarm = 1'b1;
    step(1);
    STOP_alarm = 1'b0;
    chk("alarm_stop", 32'(Alarm), 0);

`ifdef SNOOZE_EN
    load_t(0, 6, 5, 9);
    step(601);
    chk("snz_ring", 32'(Alarm), 1);
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    chk("snz_quiet", 32'(Alarm), 0);
    step(597);
    chk("snz_still_quiet", 32'(Alarm), 0);
    step(1);
    chk("snz_resume", 32'(Alarm), 1);
    chk("snz_src", 32'(alarm_src), 1);
    STOP_alarm = 1'b1;
    snooze     = 1'b1;
    step(1);
    STOP_alarm = 1'b0;
    snooze     = 1'b0;
    chk("stop_snz_alarm", 32'(Alarm), 0);
    step(700);
    chk("stop_snz_idle", 32'(Alarm), 0);
`endif

    // Disarming the ringing slot silences it
    load_t(0, 6, 5, 9);
    step(601);
    chk("disarm_ring", 32'(Alarm), 1);
    alarm_arm = 4'b1000;
    step(1);
    chk("disarm_quiet", 32'(Alarm), 0);

    // Unarmed slot 0 at 08:00 never rings
    load_a(0, 0, 8, 0, 0);
    load_t(0, 7, 5, 9);
    step(615);
    chk_time("t0800", 0, 8, 0, 0, 1);
    chk("unarmed_quiet", 32'(Alarm), 0);

    // Simultaneous load_time and load_alarm write the same hh:mm
    set_digits(0, 5, 0, 0);
    alarm_sel  = 2'd2;
    load_time  = 1'b1;
    load_alarm = 1'b1;
    step(1);
    load_time  = 1'b0;
    load_alarm = 1'b0;
    chk_time("dual_load", 0, 5, 0, 0, 0);
    alarm_arm = 4'b0100;
    load_t(0, 4, 5, 9);
    step(601);
    chk("dual_ring", 32'(Alarm), 1);
    chk("dual_src", 32'(alarm_src), 2);

    // Reset while ringing
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_ring_alarm", 32'(Alarm), 0);
    chk("rst_ring_src", 32'(alarm_src), 0);
    chk_time("rst_ring", 0, 0, 0, 0, 0);
    alarm_arm = 4'b1111;
    step(30);
    chk("rst_slots_off", 32'(Alarm), 0);

`ifdef SNOOZE_EN
    alarm_arm = 4'b0100;
    load_a(2, 0, 5, 0, 0);
    load_t(0, 4, 5, 9);
    step(601);
    chk("rst_snz_ring", 32'(Alarm), 1);
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    reset  = 1'b1;
    step(1);
    reset  = 1'b0;
    chk("rst_snz_src", 32'(alarm_src), 0);
    step(700);
    chk("rst_snz_quiet", 32'(Alarm), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_multi_alarm_clock
`default_nettype wire
